// File: rtl/spare_logic_array.sv
// spare_logic_array: ECO spare tie-low/inverter/flop inventory plus a serially loaded config register.
// Optional macro SPARE_CFG_PARITY_EN appends an even-parity bit to each frame and rejects mismatches.

module spare_tielo (
    output logic o_z
);
    assign o_z = 1'b0;
endmodule

module spare_inv (
    input  logic i_a,
    output logic o_y
);
    assign o_y = ~i_a;
endmodule

module spare_dff (
    input  logic clk,
    input  logic resetn,
    input  logic i_d,
    output logic o_q
);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) o_q <= 1'b0;
        else         o_q <= i_d;
    end
endmodule

// state  | meaning
// IDLE   | no frame in progress, cnt = 0
// SHIFT  | collecting serial bits into sr
// CHECK  | one cycle: judge length (and parity), queue the apply/reject
module spare_logic_array #(
    parameter int               N_CONST = 16,
    parameter int               N_INV   = 4,
    parameter int               N_FLOP  = 4,
    parameter int               CFG_W   = 8,
    parameter logic [CFG_W-1:0] CFG_RST = '0
) (
    input  logic               clk,
    input  logic               resetn,
    output logic [N_CONST-1:0] spare_xz,
    output logic [N_INV-1:0]   spare_xi,
    output logic [N_FLOP-1:0]  spare_xfq,
    input  logic               cfg_shift,
    input  logic               cfg_sdi,
    input  logic               cfg_strobe,
    output logic [CFG_W-1:0]   cfg_q,
    output logic               cfg_done,
    output logic               cfg_err,
    output logic               cfg_busy
);
`ifdef SPARE_CFG_PARITY_EN
    localparam int FL = CFG_W + 1;
`else
    localparam int FL = CFG_W;
`endif
    localparam int CNT_W = $clog2(FL + 2);

    // Every spare cell owns its own tie-low so any single input can be cut by an ECO.
    for (genvar g = 0; g < N_CONST; g++) begin : g_const
        spare_tielo u_tie (.o_z(spare_xz[g]));
    end

    for (genvar g = 0; g < N_INV; g++) begin : g_inv
        logic w_tie_a;
        spare_tielo u_tie (.o_z(w_tie_a));
        spare_inv   u_inv (.i_a(w_tie_a), .o_y(spare_xi[g]));
    end

    for (genvar g = 0; g < N_FLOP; g++) begin : g_flop
        logic w_tie_d;
        spare_tielo u_tie (.o_z(w_tie_d));
        spare_dff   u_dff (.clk(clk), .resetn(resetn), .i_d(w_tie_d), .o_q(spare_xfq[g]));
    end

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FL-1:0]      r_sr;
    logic [FL-1:0]      w_sr_nxt;
    logic [FL-1:0]      w_sr_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_chk;
    logic               w_par_ok;
    logic               w_accept;
    logic               r_busy;
    logic               r_pend_acc;
    logic               r_pend_rej;
    logic [CFG_W-1:0]   r_pend_data;
    logic [CFG_W-1:0]   r_cfg_q;
    logic               r_done;
    logic               r_err;

    if (FL > 1) begin : g_sr_wide
        assign w_sr_shift = {r_sr[FL-2:0], cfg_sdi};
    end else begin : g_sr_one
        assign w_sr_shift = cfg_sdi;
    end

    // Saturating at FL+1 keeps an over-long frame distinguishable from a correct one.
    assign w_cnt_inc = (r_cnt == CNT_W'(FL + 1)) ? r_cnt : r_cnt + 1'b1;

`ifdef SPARE_CFG_PARITY_EN
    assign w_par_ok = ~^r_sr;
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_accept = (r_cnt == CNT_W'(FL)) && w_par_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_chk       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_strobe) begin
                    w_state_nxt = S_CHECK;
                end else if (cfg_shift) begin
                    w_state_nxt = S_SHIFT;
                    w_sr_nxt    = w_sr_shift;
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            S_SHIFT: begin
                if (cfg_strobe) begin
                    w_state_nxt = S_CHECK;
                end else if (cfg_shift) begin
                    w_sr_nxt  = w_sr_shift;
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_CHECK: begin
                w_chk       = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // The verdict is staged one cycle so the frame is applied two edges after the strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend_acc  <= 1'b0;
            r_pend_rej  <= 1'b0;
            r_pend_data <= '0;
            r_cfg_q     <= CFG_RST;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pend_acc <= w_chk && w_accept;
            r_pend_rej <= w_chk && !w_accept;
            if (w_chk) r_pend_data <= r_sr[FL-1 -: CFG_W];
            r_done <= r_pend_acc;
            if (r_pend_acc) begin
                r_cfg_q <= r_pend_data;
                r_err   <= 1'b0;
            end else if (r_pend_rej) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cfg_q    = r_cfg_q;
    assign cfg_done = r_done;
    assign cfg_err  = r_err;
    assign cfg_busy = r_busy;

endmodule

// File: tb/tb_spare_logic_array.sv
// Table-driven bench for spare_logic_array; adapts frame length to SPARE_CFG_PARITY_EN.
module tb_spare_logic_array;
`ifdef SPARE_CFG_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int FL  = 9;
`else
    localparam bit PAR = 1'b0;
    localparam int FL  = 8;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] spare_xz;
    logic [3:0]  spare_xi;
    logic [3:0]  spare_xfq;
    logic        cfg_shift = 1'b0;
    logic        cfg_sdi = 1'b0;
    logic        cfg_strobe = 1'b0;
    logic [7:0]  cfg_q;
    logic        cfg_done;
    logic        cfg_err;
    logic        cfg_busy;

    int n_tests = 0;
    int n_fail  = 0;

    spare_logic_array #(
        .N_CONST(16), .N_INV(4), .N_FLOP(4), .CFG_W(8), .CFG_RST(8'h00)
    ) dut (
        .clk(clk), .resetn(resetn),
        .spare_xz(spare_xz), .spare_xi(spare_xi), .spare_xfq(spare_xfq),
        .cfg_shift(cfg_shift), .cfg_sdi(cfg_sdi), .cfg_strobe(cfg_strobe),
        .cfg_q(cfg_q), .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_busy(cfg_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        string      name;
        logic [7:0] data;
        int         nbits;     // -1 means a full frame of FL bits
        bit         flip_par;
        bit         same_cyc;  // extra shift bit presented together with the strobe
        bit         exp_ok;
        logic [7:0] exp_q;
        bit         exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits,
                              input bit flip_par, input bit same_cyc);
        logic [8:0] f;
        int         n;
        if (PAR) f = {data, (^data) ^ flip_par};
        else     f = {1'b0, data};
        n = (nbits < 0) ? FL : nbits;
        for (int i = 0; i < n; i++) begin
            cfg_shift = 1'b1;
            cfg_sdi   = (i < FL) ? f[FL-1-i] : 1'b1;
            @(negedge clk);
        end
        cfg_shift  = same_cyc;
        cfg_sdi    = 1'b1;
        cfg_strobe = 1'b1;
        @(negedge clk);
        cfg_shift  = 1'b0;
        cfg_strobe = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        send_frame(v.data, v.nbits, v.flip_par, v.same_cyc);
        check({v.name, " busy_in_check"}, cfg_busy, 1);
        @(negedge clk);
        check({v.name, " busy_after_check"}, cfg_busy, 0);
        check({v.name, " done_early"}, cfg_done, 0);
        @(negedge clk);
        check({v.name, " done"}, cfg_done, v.exp_ok);
        check({v.name, " q"}, cfg_q, v.exp_q);
        check({v.name, " err"}, cfg_err, v.exp_err);
        @(negedge clk);
        check({v.name, " done_single"}, cfg_done, 0);
    endtask

    initial begin
        vecs[0] = '{"load_a5",      8'hA5, -1,  1'b0, 1'b0, 1'b1,  8'hA5, 1'b0};
        vecs[1] = '{"parity_3c",    8'h3C, -1,  1'b1, 1'b0, !PAR,  PAR ? 8'hA5 : 8'h3C, PAR};
        vecs[2] = '{"load_0f",      8'h0F, -1,  1'b0, 1'b0, 1'b1,  8'h0F, 1'b0};
        vecs[3] = '{"short_7",      8'h5A, 7,   1'b0, 1'b0, 1'b0,  8'h0F, 1'b1};
        vecs[4] = '{"long_12",      8'h5A, 12,  1'b0, 1'b0, 1'b0,  8'h0F, 1'b1};
        vecs[5] = '{"idle_strobe",  8'h00, 0,   1'b0, 1'b0, 1'b0,  8'h0F, 1'b1};
        vecs[6] = '{"load_81",      8'h81, -1,  1'b0, 1'b0, 1'b1,  8'h81, 1'b0};
        vecs[7] = '{"shift_strobe", 8'hC3, -1,  1'b0, 1'b1, 1'b1,  8'hC3, 1'b0};

        #12;
        check("rst_q", cfg_q, 8'h00);
        check("rst_busy", cfg_busy, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("xz", spare_xz, 16'h0000);
        check("xi", spare_xi, 4'hF);
        check("xfq", spare_xfq, 4'h0);
        check("idle_q", cfg_q, 8'h00);
        check("idle_done", cfg_done, 0);
        check("idle_err", cfg_err, 0);
        check("idle_busy", cfg_busy, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of a frame discards it and restores CFG_RST.
        for (int i = 0; i < 4; i++) begin
            cfg_shift = 1'b1;
            cfg_sdi   = i[0];
            @(negedge clk);
        end
        cfg_shift = 1'b0;
        check("mid_busy", cfg_busy, 1);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_q", cfg_q, 8'h00);
        check("mid_rst_busy", cfg_busy, 0);
        check("mid_rst_err", cfg_err, 0);
        check("mid_rst_xfq", spare_xfq, 4'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_vec('{"post_rst_5a", 8'h5A, -1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0});
        check("final_xi", spare_xi, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
